// File: rtl/shift_subtract_divider_if.sv
// Start/done handshake bundle for the restoring divider.
// Signal suffixes are from the divider's point of view.
interface shift_subtract_divider_if #(
  parameter int N = 4
);
  logic         start_i;
  logic [N-1:0] dividend_i;
  logic [N-1:0] divisor_i;
  logic [N-1:0] quotient_o;
  logic [N-1:0] remainder_o;
  logic         busy_o;
  logic         done_o;
  logic         div_by_zero_o;

  modport slave (
    input  start_i,
    input  dividend_i,
    input  divisor_i,
    output quotient_o,
    output remainder_o,
    output busy_o,
    output done_o,
    output div_by_zero_o
  );

  modport master (
    output start_i,
    output dividend_i,
    output divisor_i,
    input  quotient_o,
    input  remainder_o,
    input  busy_o,
    input  done_o,
    input  div_by_zero_o
  );
endinterface

// File: rtl/shift_subtract_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero short-cuts straight to DONE with all-ones quotient.
module shift_subtract_divider #(
  parameter int N = 4
) (
  input logic                     clk,
  input logic                     rst,
  shift_subtract_divider_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N:0]    a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    sa;
  logic [N-1:0]  sq;
  logic [N:0]    t;

  // One shift-and-subtract step on the current partial remainder.
  always_comb begin
    sa = {a_q[N-1:0], q_q[N-1]};
    sq = {q_q[N-2:0], 1'b0};
    t  = sa - {1'b0, m_q};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          a_d   = '0;
          q_d   = bus.dividend_i;
          m_d   = bus.divisor_i;
          cnt_d = CW'(N);
          if (bus.divisor_i == '0) begin
            quot_d  = '1;
            rem_d   = bus.dividend_i;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (t[N]) begin
          a_d = sa;
          q_d = sq;
        end else begin
          a_d = t;
          q_d = sq | N'(1);
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d  = q_d;
          rem_d   = a_d[N-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.quotient_o    = quot_q;
  assign bus.remainder_o   = rem_q;
  assign bus.div_by_zero_o = dbz_q;
  assign bus.busy_o        = (state_q == CALC);
  assign bus.done_o        = (state_q == DONE);
endmodule
